// File: rtl/pcpi_result_nibble_tx.sv
// Returns a captured 32-bit PCPI result to the host as eight nibbles (LSB first)
// over a four-phase valid/ack link. Optional odd parity output: define PCPI_TX_PARITY_EN.
module pcpi_result_nibble_tx #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        res_valid,
   input  logic [31:0] res_data,
   input  logic        host_ack,
   input  logic        ovr_clr,
   output logic [3:0]  nib_out,
   output logic        nib_valid,
   output logic [2:0]  nib_idx,
   output logic        nib_last,
   output logic        nib_par,
   output logic        busy,
   output logic        overrun
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESENT = 2'd1,
      ACKED   = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [31:0]            shift_q, shift_d;
   logic [2:0]             idx_q, idx_d;
   logic [3:0]             nib_out_q, nib_out_d;
   logic                   overrun_q, overrun_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   ack_s;

   // host_ack is an asynchronous pad; only the last synchronizer stage is used.
   assign sync_d = {sync_q[SYNC_STAGES-2:0], host_ack};
   assign ack_s  = sync_q[SYNC_STAGES-1];

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      idx_d     = idx_q;
      nib_out_d = nib_out_q;
      overrun_d = overrun_q;
      if (ovr_clr) begin
         overrun_d = 1'b0;
      end
      unique case (state_q)
         IDLE: begin
            if (res_valid) begin
               shift_d   = res_data;
               idx_d     = 3'd0;
               nib_out_d = res_data[3:0];
               state_d   = PRESENT;
            end
         end
         PRESENT: begin
            if (ack_s) begin
               state_d = ACKED;
            end
         end
         ACKED: begin
            if (!ack_s) begin
               if (idx_q == 3'd7) begin
                  shift_d   = 32'd0;
                  idx_d     = 3'd0;
                  nib_out_d = 4'd0;
                  state_d   = IDLE;
               end else begin
                  shift_d   = {4'd0, shift_q[31:4]};
                  idx_d     = idx_q + 3'd1;
                  nib_out_d = shift_q[7:4];
                  state_d   = PRESENT;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // A word arriving while not IDLE (including the final ACKED cycle) is dropped.
      if (res_valid && (state_q != IDLE)) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= 32'd0;
         idx_q     <= 3'd0;
         nib_out_q <= 4'd0;
         overrun_q <= 1'b0;
         sync_q    <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         idx_q     <= idx_d;
         nib_out_q <= nib_out_d;
         overrun_q <= overrun_d;
         sync_q    <= sync_d;
      end
   end

`ifdef PCPI_TX_PARITY_EN
   logic nib_par_q, nib_par_d;

   // Registered alongside nib_out so both change on the same edge.
   assign nib_par_d = ~^nib_out_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         nib_par_q <= 1'b0;
      end else begin
         nib_par_q <= nib_par_d;
      end
   end

   assign nib_par = nib_par_q;
`else
   assign nib_par = 1'b0;
`endif

   assign nib_out   = nib_out_q;
   assign nib_idx   = idx_q;
   assign nib_valid = (state_q == PRESENT);
   assign busy      = (state_q != IDLE);
   assign nib_last  = (state_q != IDLE) && (idx_q == 3'd7);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_pcpi_result_nibble_tx.sv
// Directed bench for pcpi_result_nibble_tx: nibble order, handshake, overrun,
// held ack, asynchronous reset and parity.
module tb_pcpi_result_nibble_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        res_valid = 1'b0;
   logic [31:0] res_data = 32'd0;
   logic        host_ack = 1'b0;
   logic        ovr_clr = 1'b0;
   logic [3:0]  nib_out;
   logic        nib_valid;
   logic [2:0]  nib_idx;
   logic        nib_last;
   logic        nib_par;
   logic        busy;
   logic        overrun;

   int checks = 0;
   int errors = 0;

   pcpi_result_nibble_tx #(.SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .res_valid (res_valid),
      .res_data  (res_data),
      .host_ack  (host_ack),
      .ovr_clr   (ovr_clr),
      .nib_out   (nib_out),
      .nib_valid (nib_valid),
      .nib_idx   (nib_idx),
      .nib_last  (nib_last),
      .nib_par   (nib_par),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   function automatic logic exp_par(input logic [3:0] n);
`ifdef PCPI_TX_PARITY_EN
      return ~^n;
`else
      return 1'b0 & n[0];
`endif
   endfunction

   task automatic pulse_word(input logic [31:0] w, input logic clr);
      @(negedge clk);
      res_valid = 1'b1;
      res_data  = w;
      ovr_clr   = clr;
      @(negedge clk);
      res_valid = 1'b0;
      ovr_clr   = 1'b0;
   endtask

   task automatic wait_valid(input logic lvl, input string tag);
      int t;
      for (t = 0; t < 40 && nib_valid !== lvl; t++) @(negedge clk);
      check(tag, {31'd0, nib_valid}, {31'd0, lvl});
   endtask

   // One full four-phase handshake with a host that responds after 3 cycles.
   task automatic do_nibble(input logic [3:0] en, input logic [2:0] ei);
      int t;
      wait_valid(1'b1, "valid_rise");
      check($sformatf("nib_out[%0d]", ei), {28'd0, nib_out}, {28'd0, en});
      check($sformatf("nib_idx[%0d]", ei), {29'd0, nib_idx}, {29'd0, ei});
      check($sformatf("nib_last[%0d]", ei), {31'd0, nib_last}, {31'd0, (ei == 3'd7)});
      check($sformatf("nib_par[%0d]", ei), {31'd0, nib_par}, {31'd0, exp_par(en)});
      repeat (3) @(negedge clk);
      host_ack = 1'b1;
      wait_valid(1'b0, "valid_fall");
      check($sformatf("nib_hold[%0d]", ei), {28'd0, nib_out}, {28'd0, en});
      host_ack = 1'b0;
      for (t = 0; t < 40 && !(nib_valid || !busy); t++) @(negedge clk);
      check("next_phase", {31'd0, (nib_valid || !busy)}, 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag, input logic par_exp);
      check({tag, "_out"},   {28'd0, nib_out},   32'd0);
      check({tag, "_valid"}, {31'd0, nib_valid}, 32'd0);
      check({tag, "_idx"},   {29'd0, nib_idx},   32'd0);
      check({tag, "_last"},  {31'd0, nib_last},  32'd0);
      check({tag, "_par"},   {31'd0, nib_par},   {31'd0, par_exp});
      check({tag, "_busy"},  {31'd0, busy},      32'd0);
      check({tag, "_ovr"},   {31'd0, overrun},   32'd0);
   endtask

   initial begin
      logic [31:0] w;
      logic [31:0] w7f;
      // Reset state
      repeat (3) @(negedge clk);
      check_reset_outputs("rst", 1'b0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("idle_par", {31'd0, nib_par}, {31'd0, exp_par(4'd0)});

      // Basic word with an overrun pulse during nibble 2
      w = 32'h89ABCDEF;
      pulse_word(w, 1'b0);
      check("start_busy", {31'd0, busy}, 32'd1);
      check("start_valid", {31'd0, nib_valid}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin
            pulse_word(32'h11111111, 1'b0);
            check("overrun_set", {31'd0, overrun}, 32'd1);
         end
         do_nibble(w[4*i +: 4], 3'(i));
      end
      check("end_busy", {31'd0, busy}, 32'd0);
      check("end_out", {28'd0, nib_out}, 32'd0);
      check("end_ovr", {31'd0, overrun}, 32'd1);
      @(negedge clk);
      ovr_clr = 1'b1;
      @(negedge clk);
      ovr_clr = 1'b0;
      check("ovr_clr", {31'd0, overrun}, 32'd0);

      // Host holds ack high across the start of a transfer
      host_ack = 1'b1;
      repeat (5) @(negedge clk);
      check("held_idle_busy", {31'd0, busy}, 32'd0);
      pulse_word(32'h12345678, 1'b0);
      check("held_valid", {31'd0, nib_valid}, 32'd1);
      check("held_out0", {28'd0, nib_out}, 32'h8);
      wait_valid(1'b0, "held_fall");
      repeat (4) @(negedge clk);
      check("held_idx", {29'd0, nib_idx}, 32'd0);
      check("held_busy", {31'd0, busy}, 32'd1);
      host_ack = 1'b0;
      wait_valid(1'b1, "held_next");
      check("held_idx1", {29'd0, nib_idx}, 32'd1);
      check("held_out1", {28'd0, nib_out}, 32'h7);
      do_nibble(4'h7, 3'd1);
      do_nibble(4'h6, 3'd2);
      do_nibble(4'h5, 3'd3);
      wait_valid(1'b1, "pre_rst_valid");
      check("pre_rst_idx", {29'd0, nib_idx}, 32'd4);

      // Asynchronous reset mid-transfer
      #3 rst = 1'b1;
      #1 check_reset_outputs("async_rst", 1'b0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (nib_valid !== 1'b0 || busy !== 1'b0) begin
            check("post_rst_quiet", {30'd0, nib_valid, busy}, 32'd0);
         end
      end
      check_reset_outputs("post_rst", exp_par(4'd0));

      // res_valid with ovr_clr while busy: set wins; also exercises parity values
      w7f = 32'h0000007F;
      pulse_word(w7f, 1'b0);
      pulse_word(32'hDEADBEEF, 1'b1);
      check("ovr_set_wins", {31'd0, overrun}, 32'd1);
      for (int i = 0; i < 8; i++) begin
         do_nibble(w7f[4*i +: 4], 3'(i));
      end
      check("w7f_busy", {31'd0, busy}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
